// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the press/step controller.
//   state_t      : FSM state encoding (2 bits, all four codes named)
//   MAX_PEND_DEF : default depth of the press queue
//   TMO_CYC_DEF  : default number of WAIT cycles before a step is aborted
//   PEND_W/TMR_W : widths of the queue counter and the WAIT timer
package step_ctrl_pkg;

    localparam int MAX_PEND_DEF = 7;
    localparam int TMO_CYC_DEF  = 16;
    localparam int PEND_W       = 4;
    localparam int TMR_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating count of queued presses.
//   Clock, Reset : clock, async active-high reset
//   clear        : synchronous flush of count and ovf (highest priority)
//   inc          : a press arrived this cycle
//   dec          : a step is being issued this cycle
//   count        : registered queue depth, 0..MAX_PEND
//   ovf          : sticky, a press was dropped on a full queue
module pend_counter
    import step_ctrl_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              clear,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] MAXV = PEND_W'(MAX_PEND);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc && dec) begin
            // press and issue cancel; nothing is dropped even when full
            count <= count;
        end else if (inc) begin
            if (count == MAXV) ovf <= 1'b1;
            else               count <= count + 1'b1;
        end else if (dec) begin
            if (count != '0) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/press_step_ctrl.sv
// Turns queued button presses into one-at-a-time step requests.
//   Clock, Reset : clock, async active-high reset
//   Press        : one-cycle press pulse (queued)
//   Enable       : permits starting a new step from IDLE
//   Clear        : synchronous flush of queue, Overflow, FSM and timer
//   Done         : processor finished the outstanding step (WAIT only)
//   Step         : one-cycle step request (ISSUE state)
//   Busy         : step outstanding (WAIT state)
//   Pending      : queued press count
//   Overflow     : sticky dropped-press flag
//   Timeout      : one-cycle abort pulse (ABORT state)
module press_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_DEF,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Press,
    input  logic              Enable,
    input  logic              Clear,
    input  logic              Done,
    output logic              Step,
    output logic              Busy,
    output logic [PEND_W-1:0] Pending,
    output logic              Overflow,
    output logic              Timeout
);

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TMO_CYC - 1);

    state_t            state, nxt;
    logic [TMR_W-1:0]  timer;

    pend_counter #(.MAX_PEND(MAX_PEND)) u_pend (
        .Clock (Clock),
        .Reset (Reset),
        .clear (Clear),
        .inc   (Press),
        .dec   (state == ST_ISSUE),
        .count (Pending),
        .ovf   (Overflow)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (Pending != '0 && Enable) nxt = ST_ISSUE;
            ST_ISSUE: nxt = ST_WAIT;
            // Done wins over the timeout threshold in the same cycle
            ST_WAIT:  if (Done)                   nxt = ST_IDLE;
                      else if (timer == TMO_LAST) nxt = ST_ABORT;
            ST_ABORT: nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (Clear) nxt = ST_IDLE;
    end

    // Timer counts WAIT cycles; it is held at zero everywhere else so each
    // WAIT entry starts from 0.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                         timer <= '0;
        else if (Clear || state != ST_WAIT) timer <= '0;
        else                               timer <= timer + 1'b1;
    end

    assign Step    = (state == ST_ISSUE);
    assign Busy    = (state == ST_WAIT);
    assign Timeout = (state == ST_ABORT);

endmodule

// File: tb/tb_press_step_ctrl.sv
module tb_press_step_ctrl;

    logic       Clock = 1'b0;
    logic       Reset, Press, Enable, Clear, Done;
    logic       Step, Busy, Overflow, Timeout;
    logic [3:0] Pending;

    press_step_ctrl dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Press    (Press),
        .Enable   (Enable),
        .Clear    (Clear),
        .Done     (Done),
        .Step     (Step),
        .Busy     (Busy),
        .Pending  (Pending),
        .Overflow (Overflow),
        .Timeout  (Timeout)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       step;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
        logic       tmo;
    } out_t;

    typedef struct {
        logic  press;
        logic  en;
        logic  clr;
        logic  done;
        out_t  exp;
        string nm;
    } vec_t;

    vec_t  tbl[$];
    out_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;
    out_t  zero = '0;

    function automatic out_t o(logic s, logic b, logic [3:0] p, logic ov, logic t);
        out_t r;
        r.step = s; r.busy = b; r.pend = p; r.ovf = ov; r.tmo = t;
        return r;
    endfunction

    function automatic vec_t v(logic pr, logic en, logic cl, logic dn, out_t e, string nm);
        vec_t r;
        r.press = pr; r.en = en; r.clr = cl; r.done = dn; r.exp = e; r.nm = nm;
        return r;
    endfunction

    function automatic out_t dut_out();
        return o(Step, Busy, Pending, Overflow, Timeout);
    endfunction

    task automatic chk(input string nm, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got step=%0b busy=%0b pend=%0d ovf=%0b tmo=%0b want step=%0b busy=%0b pend=%0d ovf=%0b tmo=%0b",
                     nm, got.step, got.busy, got.pend, got.ovf, got.tmo,
                     exp.step, exp.busy, exp.pend, exp.ovf, exp.tmo);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare once the edge has happened.
    task automatic apply(input vec_t x);
        Press = x.press; Enable = x.en; Clear = x.clr; Done = x.done;
        exp_q.push_back(x.exp);
        nm_q.push_back(x.nm);
        @(posedge Clock);
        #1;
        chk(nm_q.pop_front(), dut_out(), exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- vector table ----
        // single press, Done on the 3rd busy cycle
        tbl.push_back(v(1,1,0,0, o(0,0,1,0,0), "press_lat_pend"));
        tbl.push_back(v(0,1,0,0, o(1,0,1,0,0), "issue_step"));
        tbl.push_back(v(0,1,0,0, o(0,1,0,0,0), "wait_busy1"));
        tbl.push_back(v(0,1,0,0, o(0,1,0,0,0), "wait_busy2"));
        tbl.push_back(v(0,1,0,0, o(0,1,0,0,0), "wait_busy3"));
        tbl.push_back(v(0,1,0,1, o(0,0,0,0,0), "done_idle"));
        tbl.push_back(v(0,1,0,1, o(0,0,0,0,0), "done_in_idle"));
        // saturation with Enable low
        for (int i = 0; i < 9; i++)
            tbl.push_back(v(1,0,0,0, o(0,0,4'((i < 7) ? i + 1 : 7), (i >= 7), 0), "sat_press"));
        tbl.push_back(v(0,0,0,0, o(0,0,7,1,0), "sat_hold"));
        tbl.push_back(v(1,0,1,0, o(0,0,0,0,0), "clear_with_press"));
        // full queue, press on the ISSUE cycle
        for (int i = 0; i < 7; i++)
            tbl.push_back(v(1,0,0,0, o(0,0,4'(i + 1),0,0), "fill"));
        tbl.push_back(v(0,1,0,0, o(1,0,7,0,0), "full_issue"));
        tbl.push_back(v(1,1,0,0, o(0,1,7,0,0), "press_on_issue"));
        tbl.push_back(v(0,1,0,1, o(0,0,7,0,0), "full_done"));
        tbl.push_back(v(0,1,1,0, o(0,0,0,0,0), "clear_full"));

        // ---- reset ----
        Press = 0; Enable = 0; Clear = 0; Done = 0; Reset = 0;
        #1 Reset = 1;
        #1 chk("reset_async", dut_out(), zero);
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 0;
        chk("reset_hold", dut_out(), zero);

        foreach (tbl[i]) apply(tbl[i]);

        // ---- timeout with no Done ----
        apply(v(1,1,0,0, o(0,0,1,0,0), "tmo_press"));
        apply(v(0,1,0,0, o(1,0,1,0,0), "tmo_issue"));
        for (int i = 0; i < 16; i++) apply(v(0,1,0,0, o(0,1,0,0,0), "tmo_busy"));
        apply(v(0,1,0,0, o(0,0,0,0,1), "tmo_pulse"));
        apply(v(0,1,0,0, o(0,0,0,0,0), "tmo_back_idle"));

        // ---- Done coincides with the threshold ----
        apply(v(1,1,0,0, o(0,0,1,0,0), "thr_press"));
        apply(v(0,1,0,0, o(1,0,1,0,0), "thr_issue"));
        for (int i = 0; i < 16; i++) apply(v(0,1,0,0, o(0,1,0,0,0), "thr_busy"));
        apply(v(0,1,0,1, o(0,0,0,0,0), "thr_done_wins"));
        apply(v(0,1,0,0, o(0,0,0,0,0), "thr_no_tmo"));

        // ---- reset mid-WAIT with Pending = 3 ----
        for (int i = 0; i < 4; i++) apply(v(1,0,0,0, o(0,0,4'(i + 1),0,0), "rst_fill"));
        apply(v(0,1,0,0, o(1,0,4,0,0), "rst_issue"));
        apply(v(0,1,0,0, o(0,1,3,0,0), "rst_wait1"));
        apply(v(0,1,0,0, o(0,1,3,0,0), "rst_wait2"));
        #3 Reset = 1;
        #1 chk("rst_mid_wait_async", dut_out(), zero);
        @(posedge Clock);
        #1 Reset = 0;
        chk("rst_mid_wait_hold", dut_out(), zero);
        for (int i = 0; i < 4; i++) apply(v(0,1,0,0, zero, "rst_no_step"));
        apply(v(1,1,0,0, o(0,0,1,0,0), "rst_press_lat"));
        apply(v(0,1,0,0, o(1,0,1,0,0), "rst_step_lat"));
        apply(v(0,1,0,0, o(0,1,0,0,0), "rst_wait_again"));
        apply(v(0,1,1,0, o(0,0,0,0,0), "clear_mid_wait"));
        apply(v(0,1,0,0, o(0,0,0,0,0), "clear_stays_idle"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/press_step_ctrl.md
PRESS_STEP_CTRL -- requirements
Module: press_step_ctrl

Interface
REQ-001 Parameter MAX_PEND, default 7, is the maximum number of queued presses (1..15).
REQ-002 Parameter TMO_CYC, default 16, is the number of cycles to wait for Done before abort (2..255).
REQ-003 Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Press  input  1  one-cycle press pulse from the upstream button synchronizer.
REQ-006 Enable  input  1  high = issuing of new steps permitted.
REQ-007 Clear  input  1  synchronous flush of queue, Overflow and FSM.
REQ-008 Done  input  1  processor acknowledges completion of the current step.
REQ-009 Step  output  1  one-cycle step request to the processor.
REQ-010 Busy  output  1  high while a step is outstanding.
REQ-011 Pending  output  4  registered count of queued presses.
REQ-012 Overflow  output  1  sticky flag: a press was dropped because the queue was full.
REQ-013 Timeout  output  1  one-cycle pulse: the outstanding step was aborted after TMO_CYC cycles.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and ABORT, encoded in 2 bits; any illegal encoding SHALL go to IDLE.
REQ-015 IDLE -> ISSUE when Pending != 0 and Enable = 1; otherwise stay in IDLE.
REQ-016 ISSUE SHALL last exactly one cycle, assert Step (Moore), decrement Pending at its closing edge, and go to WAIT.
REQ-017 WAIT SHALL assert Busy, increment an 8-bit timer from 0 each cycle, and go to IDLE on Done = 1.
REQ-018 WAIT -> ABORT when the timer equals TMO_CYC-1 and Done = 0; Done takes priority when both hold in the same cycle.
REQ-019 ABORT SHALL last one cycle, assert Timeout, and go to IDLE; the aborted press is not re-queued.
REQ-020 Press latency: Press at edge n -> Pending updates at n+1 -> Step high in cycle n+2 (from IDLE with Enable = 1).
REQ-021 Press with Pending < MAX_PEND -> Pending+1; Press with Pending = MAX_PEND -> Pending unchanged and Overflow set.
REQ-022 Press coinciding with the ISSUE decrement -> Pending unchanged (net zero); no overflow in this case even at MAX_PEND.
REQ-023 Pending SHALL never wrap below 0 or above MAX_PEND.
REQ-024 Done in IDLE, ISSUE or ABORT SHALL be ignored.
REQ-025 Enable = 0 SHALL block only IDLE -> ISSUE; ISSUE/WAIT/ABORT proceed, and Press is still counted.
REQ-026 Clear = 1 SHALL, at the next edge, set Pending = 0, Overflow = 0 and state = IDLE, and zero the timer; a simultaneous Press is discarded; Clear has priority over all other inputs.
REQ-027 Step and Timeout SHALL never be high in consecutive cycles; Step and Busy are mutually exclusive.

Reset
REQ-028 Reset = 1 SHALL immediately, without a clock, set state = IDLE, Pending = 0, timer = 0, Overflow = 0, and drive Step = Busy = Timeout = 0.
REQ-029 Reset asserted mid-WAIT SHALL drop the outstanding step with no Timeout pulse.
REQ-030 After Reset deasserts, the first Press SHALL follow the REQ-020 latency.

Structure
REQ-031 The state enum and the default values of MAX_PEND and TMO_CYC SHALL live in a shared package, step_ctrl_pkg.
REQ-032 The queue counter (increment/decrement/saturate/clear) SHALL be one sub-module, pend_counter; the FSM and timer stay in the top module.
REQ-033 All outputs SHALL be driven from registers or decoded state only, with no combinational path from inputs.

Verification
REQ-034 Single Press, Enable = 1, Done 3 cycles after Step -> Step in cycle n+2, Busy for 3 cycles, Pending 1 -> 0.
REQ-035 9 Presses back-to-back with Enable = 0 -> Pending saturates at 7 and Overflow = 1; Clear -> Pending = 0, Overflow = 0.
REQ-036 Press then no Done -> Busy for 16 cycles, Timeout pulses once, return to IDLE, Pending = 0.
REQ-037 Pending = 7 and a Press on the ISSUE cycle -> Pending stays 7 and Overflow remains 0.
REQ-038 Reset asserted mid-WAIT with Pending = 3 -> all outputs 0 asynchronously; no Step until a new Press.
REQ-039 Done and the timeout threshold in the same cycle -> IDLE with no Timeout; Done during IDLE -> no effect.
